cfg_lut_array: RTL
==================

// Module: cfg_lut_array
// PURPOSE
//   Parametrised array of NUM_TILES K-input LUT logic tiles, each with an optional output flip-flop.
//   Configuration is loaded through a serial bit-stream port with a valid/ready handshake, one bit per accepted beat.
//   A control FSM sequences IDLE -> LOAD -> RUN.
//   Outputs are active only once a complete bit-stream has been accepted.
//   Next-generation fabric block: it replaces hand-instantiated tiles whose configuration was poked from the testbench.
// PARAMETERS
//   NUM_TILES  8  number of logic tiles (1..64)
//   LUT_K      5  inputs per LUT (2..6)
//   CFG_BITS   derived = 2**LUT_K + 1; per-tile config: [2**LUT_K-1:0] LUT truth table, [2**LUT_K] mode (0 comb, 1 registered)
//   TOTAL_BITS derived = NUM_TILES*CFG_BITS
// PORTS
//   clock      in   1                 single clock, rising edge
//   reset      in   1                 asynchronous, active-high
//   cfg_start  in   1                 pulse: begin/restart a configuration load
//   cfg_valid  in   1                 cfg_data holds a valid bit-stream bit
//   cfg_data   in   1                 bit-stream bit
//   cfg_ready  out  1                 array accepts a bit this cycle
//   cfg_done   out  1                 high while in RUN (configuration complete)
//   run_en     in   1                 enables tile flip-flop updates in RUN
//   in_data    in   NUM_TILES*LUT_K   tile i inputs = in_data[i*LUT_K +: LUT_K]; bit 0 = LUT index LSB
//   out        out  NUM_TILES         tile outputs
// BEHAVIOUR
//   Reset (async):
//     - state = IDLE; config store, bit counter and all tile FFs = 0
//     - cfg_ready = 0, cfg_done = 0, out = 0
//   FSM:
//     - IDLE: cfg_start -> LOAD (counter cleared)
//     - LOAD: cfg_ready = 1. A bit is accepted on cfg_valid & cfg_ready.
//       Acceptance of the TOTAL_BITS-th bit -> RUN on that edge.
//       cfg_start in LOAD restarts the load: counter = 0, that cycle's bit is discarded, store is not cleared.
//     - RUN: cfg_done = 1, cfg_ready = 0, cfg_valid ignored.
//       cfg_start -> LOAD and clears all tile FFs.
//   Bit order:
//     - Stream bit j lands in flat config position j, with tile i at [i*CFG_BITS +: CFG_BITS].
//     - Tile 0's LUT bit 0 is sent first; tile NUM_TILES-1's mode bit is sent last.
//     - Implementation: right-shift register, new bit at MSB.
//     - Config store is live as it shifts, but out is masked, so partial contents are never visible.
//   LUT:
//     - lut_i = cfg_i[in_data_i], purely combinational.
//   Flip-flop:
//     - ff_i <= lut_i on clock edges where state == RUN and run_en = 1; otherwise holds.
//   Output:
//     - out[i] = (state == RUN) ? (mode_i ? ff_i : lut_i) : 0.
//     - Comb tiles: zero latency from in_data. Registered tiles: 1 cycle.
//   Boundaries:
//     - cfg_valid low in LOAD: counter holds, no timeout.
//     - Last-bit acceptance and cfg_start in the same cycle: cfg_start wins; stay in LOAD, counter = 0.
//     - reset mid-load: the store is cleared and a full reload is required.
//     - Counter width = clog2(TOTAL_BITS+1); it never wraps.
// TESTING
//   T1 Reset: assert reset asynchronously mid-cycle.
//      -> out = 0, cfg_ready = 0, cfg_done = 0 immediately; after release state = IDLE.
//   T2 (NUM_TILES=2, LUT_K=5) Load two tiles:
//      tile0 = AND(in1,in2) comb = 0x88888888, mode 0; tile1 = XOR(in1,in2) registered = 0x66666666, mode 1.
//      -> cfg_done rises exactly on the edge accepting bit 66.
//   T3 After T2: in_data tile0 = 5'b00011 -> out[0] = 1 in the same cycle; 5'b00001 -> 0.
//      tile1 = 5'b00001 with run_en = 1 -> out[1] = 1 one cycle later; run_en = 0 -> out[1] holds.
//   T4 Gapped handshake: cfg_valid toggled randomly during load.
//      -> exactly 66 accepted bits to reach RUN; result identical to T2.
//   T5 cfg_start after 30 bits, then a full 66-bit reload of new config.
//      -> RUN reached only after the second full stream; the new truth tables are in effect.
//   T6 cfg_start in RUN: cfg_done = 0, out = 0 next cycle, tile FFs cleared; reload re-enters RUN.

Source files
------------

// File: rtl/cfg_lut_array.sv
// cfg_lut_array
//   Array of NUM_TILES K-input LUT tiles, each with an optional output
//   flip-flop. The configuration is shifted in serially over a valid/ready
//   handshake (one bit per accepted beat). A small FSM sequences
//   IDLE -> LOAD -> RUN; tile outputs are forced to zero outside RUN.
// Ports
//   clock     : rising-edge clock
//   reset     : asynchronous, active-high reset
//   cfg_start : pulse, begins or restarts a configuration load
//   cfg_valid : cfg_data carries a bit-stream bit
//   cfg_data  : bit-stream bit
//   cfg_ready : high in LOAD, a bit is accepted on cfg_valid & cfg_ready
//   cfg_done  : high while in RUN
//   run_en    : enables tile flip-flop updates in RUN
//   in_data   : tile i inputs at [i*LUT_K +: LUT_K], bit 0 = LUT index LSB
//   out       : tile outputs
module cfg_lut_array #(
   parameter int NUM_TILES = 8,
   parameter int LUT_K     = 5
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          cfg_start,
   input  logic                          cfg_valid,
   input  logic                          cfg_data,
   output logic                          cfg_ready,
   output logic                          cfg_done,
   input  logic                          run_en,
   input  logic [NUM_TILES*LUT_K-1:0]    in_data,
   output logic [NUM_TILES-1:0]          out
);

   localparam int LUT_SIZE   = 2**LUT_K;
   localparam int CFG_BITS   = LUT_SIZE + 1;
   localparam int TOTAL_BITS = NUM_TILES * CFG_BITS;
   localparam int CNT_W      = $clog2(TOTAL_BITS + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [TOTAL_BITS-1:0]   r_cfg;
   logic [CNT_W-1:0]        r_cnt;
   logic [NUM_TILES-1:0]    r_ff;
   logic [NUM_TILES-1:0]    w_lut;
   logic [NUM_TILES-1:0]    w_mode;
   logic                    w_accept;
   logic                    w_last;

   // cfg_start takes priority over a bit offered in the same cycle: that bit is dropped.
   assign w_accept = (r_state == S_LOAD) && cfg_valid && !cfg_start;
   assign w_last   = w_accept && (r_cnt == CNT_W'(TOTAL_BITS - 1));

   assign cfg_ready = (r_state == S_LOAD);
   assign cfg_done  = (r_state == S_RUN);

   // Next-state logic for the load/run sequencer.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (cfg_start) w_state_nxt = S_LOAD;
            else           w_state_nxt = S_IDLE;
         end
         S_LOAD: begin
            if (cfg_start)   w_state_nxt = S_LOAD;
            else if (w_last) w_state_nxt = S_RUN;
            else             w_state_nxt = S_LOAD;
         end
         S_RUN: begin
            if (cfg_start) w_state_nxt = S_LOAD;
            else           w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Accepted-bit counter; any cfg_start clears it, and it stops at TOTAL_BITS.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)         r_cnt <= '0;
      else if (cfg_start) r_cnt <= '0;
      else if (w_accept) r_cnt <= r_cnt + CNT_W'(1);
      else               r_cnt <= r_cnt;
   end

   // Config store: right shift with the new bit entering at the MSB, so the
   // first bit sent ends up in position 0 after a full stream.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)         r_cfg <= '0;
      else if (w_accept) r_cfg <= {cfg_data, r_cfg[TOTAL_BITS-1:1]};
      else               r_cfg <= r_cfg;
   end

   // Tile flip-flops: cleared when a reload is started from RUN.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                  r_ff <= '0;
      else if (cfg_start && (r_state == S_RUN))   r_ff <= '0;
      else if ((r_state == S_RUN) && run_en)      r_ff <= w_lut;
      else                                        r_ff <= r_ff;
   end

   for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_tile
      logic [LUT_SIZE-1:0] w_tt;
      assign w_tt       = r_cfg[gi*CFG_BITS +: LUT_SIZE];
      assign w_lut[gi]  = w_tt[in_data[gi*LUT_K +: LUT_K]];
      assign w_mode[gi] = r_cfg[gi*CFG_BITS + LUT_SIZE];
   end

   // Output select; masked outside RUN so a partially shifted store is never visible.
   always_comb begin
      out = '0;
      if (r_state == S_RUN) begin
         for (int i = 0; i < NUM_TILES; i++) begin
            if (w_mode[i]) out[i] = r_ff[i];
            else           out[i] = w_lut[i];
         end
      end else begin
         out = '0;
      end
   end

endmodule
